on_chip_fsm_ocimem_engine: RTL and testbench

System-clock debug memory engine directly downstream of the Nios II debug-slave JTAG bridge. It consumes the bridge's `jdo` word and its `take_action_ocimem_*` strobes, and performs debugger reads and writes into a private on-chip monitor RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the bridge. The same RAM is exposed to the CPU through an Avalon-MM slave port, with the debugger always taking priority.

---
 rtl/on_chip_fsm_ocimem_pkg.sv | 16 +
 rtl/on_chip_fsm_ocimem_ram.sv | 22 ++
 rtl/on_chip_fsm_ocimem_engine.sv | 150 +++++++++++++++
 tb/tb_on_chip_fsm_ocimem_engine.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/on_chip_fsm_ocimem_pkg.sv
// Shared types and jdo field positions for the debug monitor-RAM engine.
package on_chip_fsm_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_CAPT,
    ST_WR
  } ocimem_state_e;

  localparam int unsigned JDO_RD_BIT    = 35;
  localparam int unsigned JDO_ADDR_LSB  = 17;
  localparam int unsigned JDO_WDATA_LSB = 3;
  localparam int unsigned JDO_WDATA_MSB = 34;

endpackage

// File: rtl/on_chip_fsm_ocimem_ram.sv
// Single-port synchronous monitor RAM: 1-cycle read latency, 4 byte lanes.
module on_chip_fsm_ocimem_ram #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/on_chip_fsm_ocimem_engine.sv
// Debugger-side monitor RAM engine: jdo command FSM, debug address counter,
// debugger-priority arbitration against the CPU Avalon-MM slave port.
module on_chip_fsm_ocimem_engine
  import on_chip_fsm_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RO_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [ADDR_W:0] RO_BASE = (ADDR_W+1)'(2**ADDR_W - RO_WORDS);

  ocimem_state_e     state_q, state_d;
  logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       mon_q, mon_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              rvalid_q, rvalid_d;

  logic              any_strobe, ro_hit, cpu_go;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata, ram_q;
  logic              jdo_unused;

  assign jdo_unused = &{1'b0, jdo[37:36], jdo[2:0]};

  assign any_strobe      = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign ro_hit          = {1'b0, dbg_addr_q} >= RO_BASE;
  assign avs_waitrequest = any_strobe || state_q == ST_RD_ISSUE || state_q == ST_WR;
  assign cpu_go          = !avs_waitrequest && (avs_read || avs_write);

  always_comb begin
    state_d    = state_q;
    dbg_addr_d = dbg_addr_q;
    wdata_d    = wdata_q;
    mon_d      = mon_q;
    ready_d    = ready_q;
    err_d      = err_q;
    rvalid_d   = !avs_waitrequest && avs_read;
    unique case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_b) begin
          state_d = ST_WR;
          wdata_d = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          ready_d = 1'b0;
        end else if (take_action_ocimem_a) begin
          dbg_addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
          err_d      = 1'b0;
          if (jdo[JDO_RD_BIT]) begin
            state_d = ST_RD_ISSUE;
            ready_d = 1'b0;
          end
        end else if (take_no_action_ocimem_a) begin
          state_d = ST_RD_ISSUE;
          ready_d = 1'b0;
        end
      end
      ST_RD_ISSUE: begin
        state_d = ST_RD_CAPT;
        if (any_strobe) err_d = 1'b1;
      end
      ST_RD_CAPT: begin
        mon_d      = ram_q;
        dbg_addr_d = dbg_addr_q + 1'b1;
        state_d    = ST_IDLE;
        ready_d    = 1'b1;
        if (any_strobe) err_d = 1'b1;
      end
      ST_WR: begin
        dbg_addr_d = dbg_addr_q + 1'b1;
        state_d    = ST_IDLE;
        ready_d    = 1'b1;
        if (any_strobe || ro_hit) err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The debugger owns the RAM port in RD_ISSUE/WR; otherwise an accepted CPU request uses it.
  always_comb begin
    ram_addr  = avs_address;
    ram_we    = 1'b0;
    ram_be    = avs_byteenable;
    ram_wdata = avs_writedata;
    if (state_q == ST_RD_ISSUE || state_q == ST_WR) begin
      ram_addr  = dbg_addr_q;
      ram_be    = '1;
      ram_wdata = wdata_q;
      ram_we    = (state_q == ST_WR) && !ro_hit;
    end else if (cpu_go) begin
      ram_we = avs_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dbg_addr_q <= '0;
      wdata_q    <= '0;
      mon_q      <= '0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dbg_addr_q <= dbg_addr_d;
      wdata_q    <= wdata_d;
      mon_q      <= mon_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rvalid_q   <= rvalid_d;
    end
  end

  on_chip_fsm_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  assign avs_readdata      = rvalid_q ? ram_q : '0;
  assign avs_readdatavalid = rvalid_q;
  assign MonDReg           = mon_q;
  assign monitor_ready     = ready_q;
  assign monitor_error     = err_q;

endmodule

// File: tb/tb_on_chip_fsm_ocimem_engine.sv
// Directed bench: default build (RO_WORDS=32) plus an unprotected build for the wrap case.
module tb_on_chip_fsm_ocimem_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_na, take_b;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;

  logic [31:0] rdata, mon, rdata_nw, mon_nw;
  logic        rvalid, wait_r, ready, err;
  logic        rvalid_nw, wait_nw, ready_nw, err_nw;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  on_chip_fsm_ocimem_engine #(.ADDR_W(8), .RO_WORDS(32)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_no_action_ocimem_a(take_na),
    .take_action_ocimem_b(take_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(rdata), .avs_readdatavalid(rvalid), .avs_waitrequest(wait_r),
    .MonDReg(mon), .monitor_ready(ready), .monitor_error(err)
  );

  on_chip_fsm_ocimem_engine #(.ADDR_W(8), .RO_WORDS(0)) dut_nw (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_no_action_ocimem_a(take_na),
    .take_action_ocimem_b(take_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(rdata_nw), .avs_readdatavalid(rvalid_nw), .avs_waitrequest(wait_nw),
    .MonDReg(mon_nw), .monitor_ready(ready_nw), .monitor_error(err_nw)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dbg_a(input logic [7:0] addr, input logic rd);
    jdo = '0;
    jdo[35] = rd;
    jdo[24:17] = addr;
    take_a = 1'b1;
    tick();
    take_a = 1'b0;
  endtask

  task automatic dbg_b(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
  endtask

  task automatic dbg_na();
    take_na = 1'b1;
    tick();
    take_na = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    avs_address = addr;
    avs_writedata = data;
    avs_byteenable = be;
    avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; jdo = '0; take_a = 0; take_na = 0; take_b = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
    tick(2);
    chk("rst_mondreg", mon, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h1);
    chk("rst_error", {31'b0, err}, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    #1;
    chk("idle_wait", {31'b0, wait_r}, 32'h0);

    // address load only, then write, then read back
    dbg_a(8'h10, 1'b0);
    chk("a_noread_ready", {31'b0, ready}, 32'h1);
    chk("a_noread_mon", mon, 32'h0);
    dbg_b(32'hDEADBEEF);
    chk("wr_ready_low", {31'b0, ready}, 32'h0);
    tick();
    chk("wr_ready_back", {31'b0, ready}, 32'h1);
    dbg_a(8'h10, 1'b1);
    chk("rd_ready_n1", {31'b0, ready}, 32'h0);
    tick();
    chk("rd_ready_n2", {31'b0, ready}, 32'h0);
    tick();
    chk("rd_ready_n3", {31'b0, ready}, 32'h1);
    chk("rd_mon", mon, 32'hDEADBEEF);

    // write-protect region
    cpu_write(8'hE0, 32'hCAFEF00D, 4'hF);
    dbg_a(8'hE0, 1'b0);
    dbg_b(32'h12345678);
    tick();
    chk("ro_error_set", {31'b0, err}, 32'h1);
    dbg_a(8'hE0, 1'b1);
    chk("ro_error_clr", {31'b0, err}, 32'h0);
    tick(2);
    chk("ro_ram_intact", mon, 32'hCAFEF00D);
    dbg_a(8'hDF, 1'b0);
    dbg_b(32'h0BADF00D);
    tick();
    chk("ro_below_err", {31'b0, err}, 32'h0);
    dbg_a(8'hDF, 1'b1);
    tick(2);
    chk("ro_below_data", mon, 32'h0BADF00D);

    // address wrap on the unprotected build
    cpu_write(8'h00, 32'h00C0FFEE, 4'hF);
    dbg_a(8'hFF, 1'b0);
    dbg_b(32'h11111111);
    tick();
    chk("wrap_err_prot", {31'b0, err}, 32'h1);
    chk("wrap_err_nw", {31'b0, err_nw}, 32'h0);
    dbg_na();
    tick(2);
    chk("wrap_read0", mon_nw, 32'h00C0FFEE);
    dbg_a(8'hFF, 1'b1);
    tick(2);
    chk("wrap_wrote_ff", mon_nw, 32'h11111111);

    // CPU read colliding with a debug write
    dbg_a(8'h20, 1'b0);
    jdo = '0;
    jdo[34:3] = 32'hA5A55A5A;
    take_b = 1'b1;
    avs_address = 8'h20;
    avs_read = 1'b1;
    #1;
    chk("coll_wait_n", {31'b0, wait_r}, 32'h1);
    tick();
    take_b = 1'b0;
    #1;
    chk("coll_wait_n1", {31'b0, wait_r}, 32'h1);
    chk("coll_rvalid_n1", {31'b0, rvalid}, 32'h0);
    tick();
    chk("coll_wait_n2", {31'b0, wait_r}, 32'h0);
    tick();
    avs_read = 1'b0;
    chk("coll_rvalid_n3", {31'b0, rvalid}, 32'h1);
    chk("coll_rdata_n3", rdata, 32'hA5A55A5A);
    tick();
    chk("coll_rvalid_pulse", {31'b0, rvalid}, 32'h0);

    // strobe during RD_CAPT is dropped
    dbg_a(8'h20, 1'b1);
    tick();
    dbg_na();
    chk("drop_error", {31'b0, err}, 32'h1);
    chk("drop_mon", mon, 32'hA5A55A5A);
    chk("drop_ready", {31'b0, ready}, 32'h1);
    tick();
    chk("drop_no_read", {31'b0, ready}, 32'h1);

    // byte enables and debug read right after a CPU write
    cpu_write(8'h30, 32'h11223344, 4'hF);
    cpu_write(8'h30, 32'hAABBCCDD, 4'b0100);
    dbg_a(8'h30, 1'b1);
    tick(2);
    chk("be_merge", mon, 32'h11BB3344);

    // reset during RD_ISSUE
    dbg_a(8'h10, 1'b1);
    reset = 1'b1;
    tick();
    chk("rst_mid_mon", mon, 32'h0);
    chk("rst_mid_ready", {31'b0, ready}, 32'h1);
    avs_address = 8'h10;
    avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    chk("rst_mid_rvalid", {31'b0, rvalid}, 32'h0);
    reset = 1'b0;
    dbg_a(8'h10, 1'b1);
    tick(2);
    chk("rst_ram_intact", mon, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
